// File: rtl/alu_op_decode_stage.sv
// ----------------------------------------------------------------------------
// alu_op_decode_stage
//
// Decode-stage pipeline register. Accepts one fetched instruction per cycle
// over a valid/ready handshake, decodes the ALU subset (ADD/SUB/XOR/OR/AND in
// register and immediate forms) and holds the result for the execute stage.
// Anything outside the subset is still forwarded, flagged as unsupported with
// every ALU enable low, and counted in a saturating counter.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   fetch-side handshake (in_ready = !out_valid || out_ready)
//   in_instr, in_pc     instruction word and its PC
//   flush               kills the held entry and any incoming instruction
//   out_valid/out_ready execute-side handshake
//   add_en..and_en      one-hot ALU enables, all zero when out_valid=0
//   use_imm, imm        operand 2 select and sign-extended I-type immediate
//   rs1, rs2, rd        register indices (rs2 forced to 0 for I-type)
//   out_pc              PC of the held instruction
//   unsupported         held instruction is outside the ALU subset
//   unsup_count         saturating count of accepted unsupported instructions
// ----------------------------------------------------------------------------
module alu_op_decode_stage #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             add_en,
    output logic             sub_en,
    output logic             xor_en,
    output logic             or_en,
    output logic             and_en,
    output logic             use_imm,
    output logic [31:0]      imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [31:0]      out_pc,
    output logic             unsupported,
    output logic [CNT_W-1:0] unsup_count
);

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Enable vector bit positions.
    localparam int unsigned EN_ADD = 0;
    localparam int unsigned EN_SUB = 1;
    localparam int unsigned EN_XOR = 2;
    localparam int unsigned EN_OR  = 3;
    localparam int unsigned EN_AND = 4;

    // ------------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_en;
    logic        w_use_imm;
    logic        w_unsup;
    logic [31:0] w_imm;
    logic [4:0]  w_rs2;
    logic        w_accept;
    logic        w_drain;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];

    always_comb begin
        w_en      = 5'b00000;
        w_use_imm = 1'b0;
        if (w_opcode == OP_REG && w_f7 == F7_BASE) begin
            case (w_f3)
                3'b000:  w_en[EN_ADD] = 1'b1;
                3'b100:  w_en[EN_XOR] = 1'b1;
                3'b110:  w_en[EN_OR]  = 1'b1;
                3'b111:  w_en[EN_AND] = 1'b1;
                default: w_en = 5'b00000;
            endcase
        end else if (w_opcode == OP_REG && w_f7 == F7_ALT && w_f3 == 3'b000) begin
            w_en[EN_SUB] = 1'b1;
        end else if (w_opcode == OP_IMM) begin
            case (w_f3)
                3'b000:  w_en[EN_ADD] = 1'b1;
                3'b100:  w_en[EN_XOR] = 1'b1;
                3'b110:  w_en[EN_OR]  = 1'b1;
                3'b111:  w_en[EN_AND] = 1'b1;
                default: w_en = 5'b00000;
            endcase
            // Unsupported OP-IMM encodings (slti etc.) must not select imm.
            w_use_imm = |w_en;
        end
    end

    assign w_unsup = ~|w_en;
    assign w_imm   = w_use_imm ? {{20{in_instr[31]}}, in_instr[31:20]} : 32'h0;
    assign w_rs2   = w_use_imm ? 5'd0 : in_instr[24:20];

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic r_valid;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;
    // Entry leaves without a replacement: consumed downstream or killed.
    assign w_drain  = flush || (r_valid && out_ready);

    // ------------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------------
    logic [4:0]       r_en;
    logic             r_use_imm;
    logic [31:0]      r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [31:0]      r_pc;
    logic             r_unsup;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_en      <= 5'b00000;
            r_use_imm <= 1'b0;
            r_imm     <= 32'h0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_rd      <= 5'd0;
            r_pc      <= 32'h0;
            r_unsup   <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_en      <= w_en;
            r_use_imm <= w_use_imm;
            r_imm     <= w_imm;
            r_rs1     <= in_instr[19:15];
            r_rs2     <= w_rs2;
            r_rd      <= in_instr[11:7];
            r_pc      <= in_pc;
            r_unsup   <= w_unsup;
            if (w_unsup && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end else if (w_drain) begin
            // Enables are cleared so the ALU never sees a stale operation.
            r_valid <= 1'b0;
            r_en    <= 5'b00000;
            r_unsup <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid   = r_valid;
    assign add_en      = r_en[EN_ADD];
    assign sub_en      = r_en[EN_SUB];
    assign xor_en      = r_en[EN_XOR];
    assign or_en       = r_en[EN_OR];
    assign and_en      = r_en[EN_AND];
    assign use_imm     = r_use_imm;
    assign imm         = r_imm;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign out_pc      = r_pc;
    assign unsupported = r_unsup;
    assign unsup_count = r_cnt;

endmodule

// File: tb/tb_alu_op_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_op_decode_stage
//
// Directed sequence followed by randomized traffic, all checked against a
// table-driven reference model of the decode rules and handshake.
// ----------------------------------------------------------------------------
module tb_alu_op_decode_stage;

    localparam int unsigned CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             add_en, sub_en, xor_en, or_en, and_en;
    logic             use_imm;
    logic [31:0]      imm;
    logic [4:0]       rs1, rs2, rd;
    logic [31:0]      out_pc;
    logic             unsupported;
    logic [CNT_W-1:0] unsup_count;

    alu_op_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .add_en      (add_en),
        .sub_en      (sub_en),
        .xor_en      (xor_en),
        .or_en       (or_en),
        .and_en      (and_en),
        .use_imm     (use_imm),
        .imm         (imm),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .out_pc      (out_pc),
        .unsupported (unsupported),
        .unsup_count (unsup_count)
    );

    always #5 clk = ~clk;

    // Expected decode. en bit order: 0 add, 1 sub, 2 xor, 3 or, 4 and.
    typedef struct {
        logic [4:0]  en;
        logic        use_imm;
        logic        unsup;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } dec_t;

    // funct3 -> enable index for the shared ADD/XOR/OR/AND encodings, -1 = none.
    int f3_map [8] = '{0, -1, -1, -1, 2, -1, 3, 4};

    int          n_vec = 0;
    int          n_err = 0;
    logic        exp_valid;
    dec_t        exp_d;
    logic [31:0] exp_pc;
    int          exp_cnt;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int   sel;
        d.en      = 5'b0;
        d.use_imm = 1'b0;
        d.unsup   = 1'b0;
        d.imm     = 32'h0;
        sel       = -1;
        if (ins[6:0] == 7'h33 && ins[31:25] == 7'h00) begin
            sel = f3_map[ins[14:12]];
        end else if (ins[6:0] == 7'h33 && ins[31:25] == 7'h20 && ins[14:12] == 3'd0) begin
            sel = 1;
        end else if (ins[6:0] == 7'h13) begin
            sel = f3_map[ins[14:12]];
            if (sel >= 0) begin
                d.use_imm = 1'b1;
                d.imm     = 32'($signed(ins[31:20]));
            end
        end
        if (sel >= 0) d.en[sel] = 1'b1;
        else d.unsup = 1'b1;
        d.rs1 = ins[19:15];
        d.rd  = ins[11:7];
        d.rs2 = d.use_imm ? 5'd0 : ins[24:20];
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: begin
                r[6:0]   = 7'h33;
                r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            end
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h33;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] dut_en();
        return {and_en, or_en, xor_en, sub_en, add_en};
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_d     = ref_decode(32'h0);
        exp_pc    = 32'h0;
        exp_cnt   = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("enables", 32'(dut_en()), exp_valid ? 32'(exp_d.en) : 32'h0);
        chk("unsup_count", 32'(unsup_count), 32'(exp_cnt));
        if (exp_valid) begin
            chk("unsupported", 32'(unsupported), 32'(exp_d.unsup));
            chk("use_imm", 32'(use_imm), 32'(exp_d.use_imm));
            chk("rs1", 32'(rs1), 32'(exp_d.rs1));
            chk("rd", 32'(rd), 32'(exp_d.rd));
            chk("out_pc", out_pc, exp_pc);
            if (!exp_d.unsup) begin
                chk("imm", imm, exp_d.imm);
                chk("rs2", 32'(rs2), 32'(exp_d.rs2));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, " enables"}, 32'(dut_en()), 32'h0);
        chk({tag, " use_imm"}, 32'(use_imm), 32'h0);
        chk({tag, " unsupported"}, 32'(unsupported), 32'h0);
        chk({tag, " imm"}, imm, 32'h0);
        chk({tag, " regs"}, 32'({rs1, rs2, rd}), 32'h0);
        chk({tag, " out_pc"}, out_pc, 32'h0);
        chk({tag, " unsup_count"}, 32'(unsup_count), 32'h0);
    endtask

    // Starts at a falling edge; drives one cycle of inputs, predicts, checks.
    task automatic step(input logic iv, input logic [31:0] ins, input logic fl,
                        input logic ordy);
        logic acc;
        dec_t d;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc_ctr;
        flush     = fl;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!exp_valid || ordy));
        acc = iv && (!exp_valid || ordy) && !fl;
        if (acc) begin
            d         = ref_decode(ins);
            exp_d     = d;
            exp_valid = 1'b1;
            exp_pc    = pc_ctr;
            if (d.unsup && exp_cnt < CNT_MAX) exp_cnt++;
        end else if (fl || (exp_valid && ordy)) begin
            exp_valid = 1'b0;
        end
        pc_ctr = pc_ctr + 32'd4;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // add x3,x1,x2
        step(1'b1, 32'h002081B3, 1'b0, 1'b1);
        chk("add add_en", 32'(add_en), 32'h1);
        chk("add regs", 32'({rs1, rs2, rd}), 32'({5'd1, 5'd2, 5'd3}));
        chk("add use_imm", 32'(use_imm), 32'h0);

        // sub then and back-to-back, no bubble
        step(1'b1, 32'h402081B3, 1'b0, 1'b1);
        chk("sub sub_en", 32'(sub_en), 32'h1);
        step(1'b1, 32'h0062F233, 1'b0, 1'b1);
        chk("and and_en", 32'(and_en), 32'h1);
        chk("and regs", 32'({rs1, rs2, rd}), 32'({5'd5, 5'd6, 5'd4}));

        // addi x5,x0,-1 and xori x1,x1,0x55
        step(1'b1, 32'hFFF00293, 1'b0, 1'b1);
        chk("addi imm", imm, 32'hFFFF_FFFF);
        chk("addi rd", 32'(rd), 32'd5);
        step(1'b1, 32'h0550C093, 1'b0, 1'b1);
        chk("xori xor_en", 32'(xor_en), 32'h1);
        chk("xori imm", imm, 32'h0000_0055);

        // Stall three cycles, then release; add x10,x10,x10 loads next edge
        for (int i = 0; i < 3; i++) step(1'b1, 32'h002081B3, 1'b0, 1'b0);
        chk("stall held imm", imm, 32'h0000_0055);
        step(1'b1, 32'h00A50533, 1'b0, 1'b1);
        chk("post-stall rd", 32'(rd), 32'd10);

        // slt is unsupported but still forwarded
        step(1'b1, 32'h003120B3, 1'b0, 1'b1);
        chk("slt unsupported", 32'(unsupported), 32'h1);
        chk("slt count", 32'(unsup_count), 32'd1);

        // Flush with an unsupported instruction arriving while an entry is held
        step(1'b1, 32'h002081B3, 1'b0, 1'b0);
        step(1'b1, 32'h003120B3, 1'b1, 1'b0);
        chk("flush out_valid", 32'(out_valid), 32'h0);
        chk("flush count", 32'(unsup_count), 32'd1);

        // Saturation at 2^CNT_W-1
        for (int i = 0; i < 5; i++) step(1'b1, 32'h003120B3, 1'b0, 1'b1);
        chk("saturated count", 32'(unsup_count), 32'd3);

        // Reset asserted mid-stall clears everything immediately
        step(1'b1, 32'h0062F233, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-stall reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rand_instr(),
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_decode_stage.md
Name: alu_op_decode_stage

Overview:
- Decode-stage pipeline register for the pipelined RISC-V core.
- Accepts fetched instructions over a valid/ready handshake and decodes the ALU subset (ADD/SUB/XOR/OR/AND, register and immediate forms).
- Registers one-hot ALU enables, operand indices and the immediate for the execute stage; the one-hot enables drive the ALU.
- Supports stall by backpressure and flush, and counts unsupported instructions.

Parameters:
CNT_W, 8, width of the saturating unsupported-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_instr  input  32  instruction word
in_pc  input  32  PC of in_instr
flush  input  1  kill held and incoming instruction (branch redirect)
out_valid  output  1  execute-stage entry valid
out_ready  input  1  execute stage consumes the entry
add_en  output  1  ALU add enable
sub_en  output  1  ALU subtract enable
xor_en  output  1  ALU xor enable
or_en  output  1  ALU or enable
and_en  output  1  ALU and enable
use_imm  output  1  arg2 comes from imm instead of rs2
imm  output  32  sign-extended I-type immediate
rs1  output  5  source register 1 index
rs2  output  5  source register 2 index (zero for I-type)
rd  output  5  destination register index
out_pc  output  32  PC of held instruction
unsupported  output  1  held instruction is outside the ALU subset
unsup_count  output  CNT_W  saturating count of accepted unsupported instructions

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all enables, use_imm and unsupported =0; imm, rs1, rs2, rd and out_pc =0; unsup_count=0. Reset mid-transfer drops the held entry.
- in_ready = !out_valid || out_ready (combinational). No in_valid -> in_ready path.
- Accept = in_valid && in_ready && !flush. On accept: all output fields load the decode of in_instr; out_valid=1 next cycle. Latency 1 cycle.
- If out_valid && out_ready && no accept: out_valid=0. Fields may hold stale values; all enables must read 0 whenever out_valid=0.
- While out_valid && !out_ready: all outputs hold stable; in_ready=0.
- flush=1: out_valid=0 next cycle and enables cleared; the incoming instruction is discarded even if in_valid=1; unsup_count is not incremented.
- Decode, where opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]:
  - 0110011, f7=0000000: f3=000 -> add_en; 100 -> xor_en; 110 -> or_en; 111 -> and_en.
  - 0110011, f7=0100000, f3=000 -> sub_en.
  - 0010011: f3 000/100/110/111 -> add/xor/or/and_en; use_imm=1; rs2=0.
  - imm = {{20{instr[31]}}, instr[31:20]} for I-type, else 0.
  - rs1 = instr[19:15]; rs2 = instr[24:20] for R-type; rd = instr[11:7].
  - Any other encoding: all enables 0, use_imm=0, unsupported=1. The entry is still passed downstream with out_valid=1, so the ALU yields 0.
- Enables are one-hot for supported instructions and all-zero otherwise; never more than one enable high.
- unsup_count increments by 1 on each accepted unsupported instruction and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous accept and out_ready: the new entry replaces the old one in the same edge; out_valid stays 1.

Test Plan:
- Reset then in_instr=0x002081B3 (add x3,x1,x2), in_valid=1, out_ready=1 -> next cycle out_valid=1, add_en=1, rs1=1, rs2=2, rd=3, use_imm=0.
- 0x402081B3 (sub) followed back-to-back by 0x0062F233 (and x4,x5,x6) -> consecutive cycles show sub_en, then and_en with rs1=5, rs2=6, rd=4; no bubble.
- 0xFFF00293 (addi x5,x0,-1) -> add_en=1, use_imm=1, imm=0xFFFFFFFF, rd=5; 0x0550C093 (xori x1,x1,0x55) -> xor_en=1, imm=0x00000055.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and outputs stable; release -> next instruction loads on the following edge.
- 0x003120B3 (slt) -> out_valid=1, all enables 0, unsupported=1, unsup_count=1. With CNT_W=2, send 5 unsupported instructions -> count saturates at 3.
- flush=1 together with in_valid=1 while an entry is held -> next cycle out_valid=0, all enables 0, unsup_count unchanged. Assert rst_n=0 mid-stall -> all outputs 0 immediately.
